bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that sits directly upstream of the 4-bit BCD adder datapath. It accepts an unsigned binary word over a valid/ready handshake and returns packed BCD digits over a second valid/ready handshake. Each 4-bit digit of the output is ready to drive one BCD adder operand nibble.

---
 rtl/bin_to_bcd_seq_if.sv | 56 +++++
 rtl/bin_to_bcd_seq.sv | 177 +++++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : bin_to_bcd_seq_if
//  Purpose  : Bundles both valid/ready handshakes of the sequential
//             binary-to-BCD converter, together with its status flags.
//  Ports    : (interface signals)
//             in_valid  - producer has a binary word on bin_in
//             in_ready  - converter can accept a word
//             bin_in    - unsigned binary operand, BIN_W bits
//             out_valid - bcd_out holds a completed result
//             out_ready - consumer accepts the result
//             bcd_out   - packed BCD, digit k at [4k+3:4k], digit 0 = units
//             busy      - converter is shifting
//             ovf       - result exceeded 10^DIGITS-1
//  Modports : master - producer/consumer side (drives inputs, observes outputs)
//             slave  - converter side
//  Revision : 1.0 - initial release
// ============================================================================
interface bin_to_bcd_seq_if #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
);

   logic                  in_valid;
   logic                  in_ready;
   logic [BIN_W-1:0]      bin_in;
   logic                  out_valid;
   logic                  out_ready;
   logic [4*DIGITS-1:0]   bcd_out;
   logic                  busy;
   logic                  ovf;

   modport master (
      output in_valid,
      output bin_in,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  bcd_out,
      input  busy,
      input  ovf
   );

   modport slave (
      input  in_valid,
      input  bin_in,
      input  out_ready,
      output in_ready,
      output out_valid,
      output bcd_out,
      output busy,
      output ovf
   );

endinterface
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bin_to_bcd_seq
//  Purpose  : Sequential binary-to-BCD converter using shift-and-add-3, one
//             binary bit per clock. Accepts one unsigned word at a time and
//             returns packed BCD digits; each output nibble can drive one
//             operand nibble of the downstream BCD adder.
//  Ports    : clk      - sole clock, rising edge
//             rst      - synchronous, active-high reset
//             conv_io  - bin_to_bcd_seq_if.slave (input and output
//                        handshakes, bcd_out, busy, ovf)
//  Params   : BIN_W  (>=1) binary input width
//             DIGITS (>=1) number of BCD output digits
//  Macro    : BIN_TO_BCD_SEQ_OVF_EN - when defined, builds the sticky
//             overflow flag; when undefined, ovf is tied low.
//  Latency  : BIN_W cycles from accept edge to out_valid; peak throughput
//             one word every BIN_W+2 cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  wire logic          clk,
   input  wire logic          rst,
   bin_to_bcd_seq_if.slave    conv_io
);

   localparam int c_BCD_W = 4 * DIGITS;
   localparam int c_CNT_W = $clog2(BIN_W + 1);

   localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(BIN_W);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t               state_q,  state_d;
   logic [BIN_W-1:0]     bin_q,    bin_d;    // binary shift register
   logic [c_BCD_W-1:0]   work_q,   work_d;   // working BCD register
   logic [c_CNT_W-1:0]   cnt_q,    cnt_d;    // remaining shift steps
   logic [c_BCD_W-1:0]   bcd_q,    bcd_d;    // published result

   logic                 w_accept;
   logic [c_BCD_W-1:0]   w_adj;              // work_q after add-3 correction
   logic [c_BCD_W:0]     w_shift;            // {adjusted bcd, bin msb}
   logic                 w_drop;             // bit pushed out of the top digit

   assign w_accept = (state_q == S_IDLE) && conv_io.in_valid;

   // ------------------------------------------------------------------------
   // Add-3 correction: any digit >= 5 would become >= 10 after the shift,
   // so pre-adding 3 makes the shift carry it into the next digit.
   // ------------------------------------------------------------------------
   generate
      for (genvar k = 0; k < DIGITS; k++) begin : g_digit
         assign w_adj[4*k +: 4] = (work_q[4*k +: 4] >= 4'd5)
                                ? (work_q[4*k +: 4] + 4'd3)
                                : work_q[4*k +: 4];
      end
   endgenerate

   // The top bit of the concatenation is the one discarded on overflow;
   // the remaining bits therefore track bin_in mod 10^DIGITS.
   assign w_shift = {w_adj, bin_q[BIN_W-1]};
   assign w_drop  = w_shift[c_BCD_W];

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         bin_q   <= '0;
         work_q  <= '0;
         cnt_q   <= '0;
         bcd_q   <= '0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state and datapath
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;

      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               bin_d   = conv_io.bin_in;
               work_d  = '0;
               cnt_d   = c_CNT_LOAD;
               state_d = S_SHIFT;
            end
         end

         S_SHIFT: begin
            work_d = w_shift[c_BCD_W-1:0];
            bin_d  = bin_q << 1;
            cnt_d  = cnt_q - c_CNT_ONE;
            // Last step: the counter is about to reach zero, so the value
            // being shifted in is final and goes straight to the output.
            if (cnt_q == c_CNT_ONE) begin
               bcd_d   = w_shift[c_BCD_W-1:0];
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            if (conv_io.out_ready) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Overflow flag
   // ------------------------------------------------------------------------
`ifdef BIN_TO_BCD_SEQ_OVF_EN
   logic ovf_q, ovf_d;

   always_comb begin
      ovf_d = ovf_q;
      if (w_accept) begin
         ovf_d = 1'b0;
      end else if ((state_q == S_SHIFT) && w_drop) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign conv_io.ovf = ovf_q;
`else
   // Discarded bit has no observer in this build.
   logic w_unused_drop;
   assign w_unused_drop = w_drop;
   assign conv_io.ovf   = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Outputs: decoded from registered state only
   // ------------------------------------------------------------------------
   assign conv_io.in_ready  = (state_q == S_IDLE);
   assign conv_io.busy      = (state_q == S_SHIFT);
   assign conv_io.out_valid = (state_q == S_DONE);
   assign conv_io.bcd_out   = bcd_q;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bin_to_bcd_seq
//  Purpose  : Directed self-checking bench for bin_to_bcd_seq. Three
//             instances: default (8b/3 digits), 8b/2 digits (overflow),
//             4b/2 digits (full sweep).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

`ifdef BIN_TO_BCD_SEQ_OVF_EN
   localparam logic c_OVF_ON = 1'b1;
`else
   localparam logic c_OVF_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(3)) if_a ();
   bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(2)) if_b ();
   bin_to_bcd_seq_if #(.BIN_W(4), .DIGITS(2)) if_c ();

   bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_a (.clk(clk), .rst(rst), .conv_io(if_a));
   bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_b (.clk(clk), .rst(rst), .conv_io(if_b));
   bin_to_bcd_seq #(.BIN_W(4), .DIGITS(2)) u_c (.clk(clk), .rst(rst), .conv_io(if_c));

   int  n_cmp = 0;
   int  n_err = 0;
   time t_acc  = 0;
   time t_prev = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Default instance: convert, optionally hold out_ready low for 'hold'
   // cycles after out_valid while presenting a stray in_valid.
   task automatic conv_a(input logic [7:0] b, input logic [11:0] exp, input int hold, input string tag);
      int lat;
      int low;
      chk({tag, "_idle_ready"}, 32'(if_a.in_ready), 32'd1);
      if_a.bin_in    = b;
      if_a.in_valid  = 1'b1;
      if_a.out_ready = (hold == 0);
      tick();
      t_prev = t_acc;
      t_acc  = $time;
      if_a.in_valid = 1'b0;
      if_a.bin_in   = 8'hA5;
      chk({tag, "_busy"}, 32'(if_a.busy), 32'd1);
      low = (if_a.in_ready == 1'b0) ? 1 : 0;
      lat = 0;
      while (!if_a.out_valid && lat < 20) begin
         tick();
         lat++;
         if (if_a.in_ready == 1'b0) low++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'd8);
      chk({tag, "_ready_low_cycles"}, 32'(low), 32'd9);
      chk({tag, "_bcd"}, 32'(if_a.bcd_out), 32'(exp));
      chk({tag, "_ovf"}, 32'(if_a.ovf), 32'd0);
      for (int i = 0; i < hold; i++) begin
         if_a.in_valid = 1'b1;
         if_a.bin_in   = 8'd77;
         chk({tag, "_hold_valid"}, 32'(if_a.out_valid), 32'd1);
         chk({tag, "_hold_bcd"}, 32'(if_a.bcd_out), 32'(exp));
         chk({tag, "_hold_ready"}, 32'(if_a.in_ready), 32'd0);
         tick();
      end
      if_a.in_valid = 1'b0;
      chk({tag, "_prerelease_valid"}, 32'(if_a.out_valid), 32'd1);
      if_a.out_ready = 1'b1;
      tick();
      chk({tag, "_post_valid"}, 32'(if_a.out_valid), 32'd0);
      chk({tag, "_post_ready"}, 32'(if_a.in_ready), 32'd1);
      chk({tag, "_post_bcd_kept"}, 32'(if_a.bcd_out), 32'(exp));
   endtask

   task automatic conv_b(input logic [7:0] b, input logic [7:0] exp, input logic exp_ovf, input string tag);
      int lat;
      if_b.bin_in    = b;
      if_b.in_valid  = 1'b1;
      if_b.out_ready = 1'b1;
      tick();
      if_b.in_valid = 1'b0;
      lat = 0;
      while (!if_b.out_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'd8);
      chk({tag, "_bcd"}, 32'(if_b.bcd_out), 32'(exp));
      chk({tag, "_ovf"}, 32'(if_b.ovf), 32'(exp_ovf));
      tick();
      chk({tag, "_post_ready"}, 32'(if_b.in_ready), 32'd1);
   endtask

   task automatic conv_c(input logic [3:0] b, input logic [7:0] exp, input string tag);
      int lat;
      if_c.bin_in    = b;
      if_c.in_valid  = 1'b1;
      if_c.out_ready = 1'b1;
      tick();
      if_c.in_valid = 1'b0;
      lat = 0;
      while (!if_c.out_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'd4);
      chk({tag, "_bcd"}, 32'(if_c.bcd_out), 32'(exp));
      tick();
   endtask

   initial begin
      int stray;
      logic [7:0] e;
      if_a.in_valid = 1'b0; if_a.bin_in = '0; if_a.out_ready = 1'b0;
      if_b.in_valid = 1'b0; if_b.bin_in = '0; if_b.out_ready = 1'b0;
      if_c.in_valid = 1'b0; if_c.bin_in = '0; if_c.out_ready = 1'b0;

      // Reset state
      rst = 1'b1;
      tick();
      tick();
      chk("rst_in_ready",  32'(if_a.in_ready),  32'd1);
      chk("rst_out_valid", 32'(if_a.out_valid), 32'd0);
      chk("rst_busy",      32'(if_a.busy),      32'd0);
      chk("rst_ovf",       32'(if_a.ovf),       32'd0);
      chk("rst_bcd",       32'(if_a.bcd_out),   32'd0);
      rst = 1'b0;
      tick();

      // 255 with out_ready held high
      conv_a(8'd255, 12'h255, 0, "a255");

      // 0 then 99 back-to-back at minimum spacing
      conv_a(8'd0,  12'h000, 0, "a0");
      conv_a(8'd99, 12'h099, 0, "a99");
      chk("b2b_spacing", 32'((t_acc - t_prev) / 10), 32'd10);

      // Output backpressure for 5 cycles
      conv_a(8'd128, 12'h128, 5, "a128");

      // Reset during the 4th shift cycle of 200
      if_a.bin_in    = 8'd200;
      if_a.in_valid  = 1'b1;
      if_a.out_ready = 1'b1;
      tick();
      if_a.in_valid = 1'b0;
      tick();
      tick();
      tick();
      chk("midrst_busy_before", 32'(if_a.busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_out_valid", 32'(if_a.out_valid), 32'd0);
      chk("midrst_in_ready",  32'(if_a.in_ready),  32'd1);
      chk("midrst_busy",      32'(if_a.busy),      32'd0);
      chk("midrst_bcd",       32'(if_a.bcd_out),   32'd0);
      stray = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (if_a.out_valid) stray++;
      end
      chk("midrst_no_result", 32'(stray), 32'd0);
      conv_a(8'd37, 12'h037, 0, "a37");

      // Two-digit instance: overflow case then clean case
      conv_b(8'd200, 8'h00, c_OVF_ON, "b200");
      conv_b(8'd99,  8'h99, 1'b0,     "b99");

      // Four-bit sweep
      for (int v = 0; v < 16; v++) begin
         e = 8'(((v / 10) << 4) | (v % 10));
         conv_c(4'(v), e, $sformatf("c%0d", v));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
